// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for a bank of common-anode 7-segment
// digits. Each frame is double-buffered so that an update never tears
// mid-scan, and optional all-off cycles after each digit suppress ghosting.
module seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int BLANK  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_load,
  input  logic [8*DIGITS-1:0] i_seg,
  output logic [DIGITS-1:0]   o_an,
  output logic [7:0]          o_seg,
  output logic                o_frame
);

  localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit HAS_BLANK = (BLANK > 0);

  localparam logic [CW-1:0]     DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = '1;
  localparam logic [DIGITS-1:0] AN_D0      = ~DIGITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_idx;
  logic [CW-1:0]          r_cnt;
  logic                   r_pend;
  logic [DIGITS-1:0][7:0] r_active;
  logic [DIGITS-1:0][7:0] r_pending;
  logic [DIGITS-1:0]      r_an;
  logic [7:0]             r_seg;
  logic                   r_frame;

  logic                   w_last_phase;
  logic                   w_boundary;
  logic                   w_swap;
  logic [IW-1:0]          w_idx_next;
  logic [DIGITS-1:0][7:0] w_active_nxt;
  logic [DIGITS-1:0][7:0] w_pending_nxt;
  logic                   w_pend_nxt;
  logic [DIGITS-1:0]      w_an_next;
  logic [7:0]             w_seg_next;

  // The last cycle of a digit is the end of its blank phase, or the end of
  // its lit phase when there is no blanking.
  assign w_last_phase = HAS_BLANK ? (r_state == S_BLANK && r_cnt == BLANK_LAST)
                                  : (r_state == S_SHOW  && r_cnt == DIV_LAST);

  // Frame boundary: leaving the last digit while still enabled. Buffers may
  // only change here or while idle, so a displayed frame is never mixed.
  assign w_boundary = i_en && w_last_phase && (r_idx == IDX_LAST);
  assign w_swap     = w_boundary || (r_state == S_IDLE);
  assign w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);

  // Next contents of the double buffer; a load that lands on a swap goes
  // straight to the active buffer so the newest data is never delayed.
  // NOTE: every always_comb output gets a default first, otherwise a path
  // that skips an assignment infers a latch.
  always_comb begin
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    w_pend_nxt    = r_pend;
    if (i_load) begin
      w_pending_nxt = i_seg;
    end
    if (w_swap) begin
      if (i_load) begin
        w_active_nxt = i_seg;
      end else if (r_pend) begin
        w_active_nxt = r_pending;
      end
      w_pend_nxt = 1'b0;
    end else if (i_load) begin
      w_pend_nxt = 1'b1;
    end
  end

  // Anode select and segment pattern for the digit that lights next,
  // taken from the post-swap buffer so a new frame shows from digit 0.
  always_comb begin
    w_an_next  = AN_OFF;
    w_seg_next = 8'hFF;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_idx_next == IW'(k)) begin
        w_an_next[k] = 1'b0;
        w_seg_next   = w_active_nxt[k];
      end
    end
  end

  // Frame buffers: pending holds the next frame, active is what is scanned.
  // NOTE: these small buffers are reset so the display is guaranteed dark
  // (8'hFF) before the first load; large memories normally are not reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active  <= '1;
      r_pending <= '1;
      r_pend    <= 1'b0;
    end else begin
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
      r_pend    <= w_pend_nxt;
    end
  end

  // Scan FSM with registered outputs: IDLE (dark), SHOW (digit lit), BLANK.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_an    <= AN_OFF;
      r_seg   <= 8'hFF;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_boundary;
      if (!i_en) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_an    <= AN_OFF;
        r_seg   <= 8'hFF;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_SHOW;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_an    <= AN_D0;
            r_seg   <= w_active_nxt[0];
          end
          S_SHOW: begin
            if (r_cnt != DIV_LAST) begin
              r_cnt <= r_cnt + CW'(1);
            end else if (HAS_BLANK) begin
              r_state <= S_BLANK;
              r_cnt   <= '0;
              r_an    <= AN_OFF;
              r_seg   <= 8'hFF;
            end else begin
              r_idx <= w_idx_next;
              r_cnt <= '0;
              r_an  <= w_an_next;
              r_seg <= w_seg_next;
            end
          end
          S_BLANK: begin
            if (r_cnt != BLANK_LAST) begin
              r_cnt <= r_cnt + CW'(1);
            end else begin
              r_state <= S_SHOW;
              r_idx   <= w_idx_next;
              r_cnt   <= '0;
              r_an    <= w_an_next;
              r_seg   <= w_seg_next;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_an    <= AN_OFF;
            r_seg   <= 8'hFF;
          end
        endcase
      end
    end
  end

  assign o_an    = r_an;
  assign o_seg   = r_seg;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: vector table, directed corner sequences and randomized
// stimulus against a timeline-based reference model of the scanner.
module tb_seg_scan;

  localparam int D  = 4;
  localparam int DV = 4;
  localparam int BL = 1;
  localparam int P  = DV + BL;   // cycles per digit slot
  localparam int FR = D * P;     // cycles per frame

  logic        clk = 1'b0;
  logic        r_rst = 1'b0;
  logic        r_en = 1'b0;
  logic        r_load = 1'b0;
  logic [31:0] r_seg = '0;

  logic [3:0]  w_an;
  logic [7:0]  w_seg;
  logic        w_frame;
  logic [0:0]  w1_an;
  logic [7:0]  w1_seg;
  logic        w1_frame;

  always #5 clk = ~clk;

  seg_scan #(.DIGITS(D), .DIV(DV), .BLANK(BL)) u_dut (
    .i_clk   (clk),
    .i_rst   (r_rst),
    .i_en    (r_en),
    .i_load  (r_load),
    .i_seg   (r_seg),
    .o_an    (w_an),
    .o_seg   (w_seg),
    .o_frame (w_frame)
  );

  seg_scan #(.DIGITS(1), .DIV(1), .BLANK(0)) u_one (
    .i_clk   (clk),
    .i_rst   (r_rst),
    .i_en    (r_en),
    .i_load  (r_load),
    .i_seg   (r_seg[7:0]),
    .o_an    (w1_an),
    .o_seg   (w1_seg),
    .o_frame (w1_frame)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: time since enable, buffers as plain arrays.
  int         m_t;
  bit         m_run;
  logic [7:0] m_act [D];
  logic [7:0] m_pnd [D];
  bit         m_pend;
  logic [3:0] m_an;
  logic [7:0] m_seg;
  logic       m_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_main(input string name);
    check(name, {19'b0, w_an, w_seg, w_frame}, {19'b0, m_an, m_seg, m_frame});
  endtask

  task automatic model_reset();
    m_t = 0; m_run = 0; m_pend = 0;
    for (int k = 0; k < D; k++) begin
      m_act[k] = 8'hFF;
      m_pnd[k] = 8'hFF;
    end
    m_an = 4'hF; m_seg = 8'hFF; m_frame = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic model_step();
    bit was_idle;
    bit bnd;
    int d;
    was_idle = !m_run;
    bnd = 0;
    if (!r_en) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_t = 0;
    end else begin
      m_t++;
      bnd = (m_t % FR) == 0;
    end
    if (was_idle || bnd) begin
      for (int k = 0; k < D; k++) begin
        if (r_load) m_act[k] = r_seg[8*k +: 8];
        else if (m_pend) m_act[k] = m_pnd[k];
      end
      m_pend = 0;
    end else if (r_load) begin
      for (int k = 0; k < D; k++) m_pnd[k] = r_seg[8*k +: 8];
      m_pend = 1;
    end
    m_an = 4'hF; m_seg = 8'hFF; m_frame = bnd;
    if (m_run && (m_t % P) < DV) begin
      d = (m_t / P) % D;
      m_an[d] = 1'b0;
      m_seg = m_act[d];
    end
  endtask

  task automatic tick(input logic en, input logic load, input logic [31:0] seg);
    r_en = en; r_load = load; r_seg = seg;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    r_rst = 1'b1;
    model_reset();
    #3;
    r_rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        load;
    logic [31:0] seg;
    logic [3:0]  an;
    logic [7:0]  sg;
    logic        fr;
    int          reps;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_f;
    logic [31:0] new_f;
    logic [31:0] b4_f;

    vecs[0]  = '{1'b0, 1'b1, 32'h99B0A4F9, 4'hF, 8'hFF, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        4'hE, 8'hF9, 1'b0, 4};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        4'hF, 8'hFF, 1'b0, 1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        4'hD, 8'hA4, 1'b0, 4};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        4'hF, 8'hFF, 1'b0, 1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        4'hB, 8'hB0, 1'b0, 4};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        4'hF, 8'hFF, 1'b0, 1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        4'h7, 8'h99, 1'b0, 4};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        4'hF, 8'hFF, 1'b0, 1};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,        4'hE, 8'hF9, 1'b1, 1};
    vecs[10] = '{1'b1, 1'b0, 32'h0,        4'hE, 8'hF9, 1'b0, 3};
    vecs[11] = '{1'b1, 1'b0, 32'h0,        4'hF, 8'hFF, 1'b0, 1};

    // Reset state, checked while reset is held.
    r_rst = 1'b1;
    model_reset();
    #2;
    check("reset_main", {19'b0, w_an, w_seg, w_frame}, {19'b0, 4'hF, 8'hFF, 1'b0});
    check("reset_one", {23'b0, w1_an, w1_seg, w1_frame}, {23'b0, 1'b1, 8'hFF, 1'b0});
    #1;
    r_rst = 1'b0;
    #1;

    // Load in IDLE then scan: full frame sequence from the table.
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        tick(vecs[i].en, vecs[i].load, vecs[i].seg);
        check($sformatf("vec%0d_%0d", i, r), {19'b0, w_an, w_seg, w_frame},
              {19'b0, vecs[i].an, vecs[i].sg, vecs[i].fr});
      end
    end

    // Tearing: a load during digit 1 appears only from the next frame.
    old_f = 32'h11223344;
    new_f = 32'h55667788;
    do_reset();
    tick(1'b0, 1'b1, old_f);
    check_main("tear_idle");
    tick(1'b1, 1'b0, 32'h0);
    check_main("tear_t0");
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      check_main("tear_pre");
    end
    tick(1'b1, 1'b1, new_f);
    check_main("tear_load");
    for (int k = 7; k <= 20; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      check_main("tear_run");
      if (k == 11) check("tear_d2_old", {24'b0, w_seg}, {24'b0, old_f[23:16]});
      if (k == 16) check("tear_d3_old", {24'b0, w_seg}, {24'b0, old_f[31:24]});
      if (k == 20) check("tear_d0_new", {19'b0, w_an, w_seg, w_frame},
                         {19'b0, 4'hE, new_f[7:0], 1'b1});
    end

    // Load exactly on the boundary cycle is shown immediately.
    b4_f = 32'hA1B2C3D4;
    for (int k = 21; k <= 39; k++) begin
      tick(1'b1, 1'b0, $urandom);
      check_main("bnd_pre");
    end
    tick(1'b1, 1'b1, b4_f);
    check("bnd_load_d0", {19'b0, w_an, w_seg, w_frame}, {19'b0, 4'hE, b4_f[7:0], 1'b1});
    for (int k = 41; k <= 45; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      check_main("bnd_post");
      if (k == 45) check("bnd_load_d1", {24'b0, w_seg}, {24'b0, b4_f[15:8]});
    end

    // Drop enable during a blank phase, then re-enable.
    for (int k = 46; k <= 49; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      check_main("gap_pre");
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      check("gap_dark", {19'b0, w_an, w_seg, w_frame}, {19'b0, 4'hF, 8'hFF, 1'b0});
    end
    tick(1'b1, 1'b0, 32'h0);
    check("gap_relight", {19'b0, w_an, w_seg, w_frame}, {19'b0, 4'hE, b4_f[7:0], 1'b0});
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      check_main("gap_run");
    end

    // Asynchronous reset while digit 2 is lit.
    do_reset();
    tick(1'b0, 1'b1, 32'hCAFE0123);
    tick(1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b0, 32'h0);
    end
    check("rst_pre_d2", {19'b0, w_an, w_seg, w_frame}, {19'b0, 4'hB, 8'hFE, 1'b0});
    #2;
    r_rst = 1'b1;
    #1;
    check("rst_async", {19'b0, w_an, w_seg, w_frame}, {19'b0, 4'hF, 8'hFF, 1'b0});
    model_reset();
    #2;
    r_rst = 1'b0;
    tick(1'b1, 1'b0, 32'h0);
    check("rst_relight", {19'b0, w_an, w_seg, w_frame}, {19'b0, 4'hE, 8'hFF, 1'b0});
    check_main("rst_relight_model");

    // Randomized stimulus against the model.
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0), $urandom);
      check_main("rand");
    end

    // Single digit, no blanking, one-cycle lit phase.
    do_reset();
    tick(1'b0, 1'b1, 32'h0000005A);
    check("one_idle", {23'b0, w1_an, w1_seg, w1_frame}, {23'b0, 1'b1, 8'hFF, 1'b0});
    tick(1'b1, 1'b0, 32'h0);
    check("one_first", {23'b0, w1_an, w1_seg, w1_frame}, {23'b0, 1'b0, 8'h5A, 1'b0});
    tick(1'b1, 1'b0, 32'h0);
    check("one_frame", {23'b0, w1_an, w1_seg, w1_frame}, {23'b0, 1'b0, 8'h5A, 1'b1});
    tick(1'b1, 1'b1, 32'h000000C3);
    check("one_load", {23'b0, w1_an, w1_seg, w1_frame}, {23'b0, 1'b0, 8'hC3, 1'b1});
    tick(1'b1, 1'b0, 32'h0);
    check("one_hold", {23'b0, w1_an, w1_seg, w1_frame}, {23'b0, 1'b0, 8'hC3, 1'b1});
    tick(1'b0, 1'b0, 32'h0);
    check("one_dark", {23'b0, w1_an, w1_seg, w1_frame}, {23'b0, 1'b1, 8'hFF, 1'b0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
